// File: rtl/mult_8_seq.sv
// ---------------------------------------------------------------------------
// mult_8_seq : sequential 8x8 unsigned shift-and-add multiplier.
//
// A single 8-bit ripple-carry adder (add_8) is reused over eight iterations
// to build a 16-bit product. A request is accepted in IDLE, the datapath
// iterates for eight CALC cycles, and DONE pulses for one cycle with the
// registered product already valid.
//
// Ports (mult_8_seq):
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request, sampled only while ready=1
//   a        in   8   multiplicand, captured on the accepting edge
//   b        in   8   multiplier, captured on the accepting edge
//   ready    out  1   high in IDLE
//   busy     out  1   high in CALC
//   done     out  1   one-cycle pulse in DONE
//   product  out  16  last completed result (registered)
//
// Ports (add_8):
//   a, b     in   8   addends
//   cin      in   1   carry in
//   sum      out  8   sum
//   co       out  1   carry out
// ---------------------------------------------------------------------------

module add_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       co
);

   logic [8:0] carry;

   // Explicit ripple chain of full adders, LSB first.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign co = carry[8];

endmodule

module mult_8_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  mcand_q;
   logic [7:0]  acc_q;
   logic [7:0]  mq_q;
   logic [2:0]  cnt_q;
   logic [15:0] product_q;

   logic [7:0]  addend;
   logic [7:0]  sum;
   logic        co;
   logic [15:0] acc_mq_d;

   // Partial product is the multiplicand gated by the current multiplier LSB.
   assign addend = mq_q[0] ? mcand_q : 8'h00;

   add_8 u_add (
      .a   (acc_q),
      .b   (addend),
      .cin (1'b0),
      .sum (sum),
      .co  (co)
   );

   // Adder carry becomes the new accumulator MSB; the consumed multiplier
   // bit falls off the bottom, so {acc,mq} stays exactly 16 bits wide.
   assign acc_mq_d = {co, sum, mq_q[7:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q <= a;
                  mq_q    <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               {acc_q, mq_q} <= acc_mq_d;
               cnt_q         <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  product_q <= acc_mq_d;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Status flags are pure state decodes, so they are mutually exclusive
   // and have no path from start/a/b.
   assign ready   = (state_q == IDLE);
   assign busy    = (state_q == CALC);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_mult_8_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_8_seq : self-checking bench for mult_8_seq.
// A transaction-level reference (accept -> 8 busy cycles -> done with a*b)
// is compared against the DUT every cycle, alongside directed vectors with
// hand-computed products.
// ---------------------------------------------------------------------------

module tb_mult_8_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int total_checks;
   int passed_checks;

   mult_8_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act === exp) passed_checks++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: phase 0 = idle, 1..8 = computing, 9 = result presented.
   int          m_phase;
   logic [15:0] m_pend;
   logic [15:0] m_prod;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_pend  <= 16'h0;
         m_prod  <= 16'h0;
      end else begin
         if (m_phase == 0) begin
            if (start) begin
               m_pend  <= {8'h00, a} * {8'h00, b};
               m_phase <= 1;
            end
         end else if (m_phase == 8) begin
            m_prod  <= m_pend;
            m_phase <= 9;
         end else if (m_phase == 9) begin
            m_phase <= 0;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_ready", {31'd0, ready}, {31'd0, m_phase == 0});
         check("model_busy", {31'd0, busy}, {31'd0, (m_phase >= 1) && (m_phase <= 8)});
         check("model_done", {31'd0, done}, {31'd0, m_phase == 9});
         check("model_product", {16'd0, product}, {16'd0, m_prod});
      end
   end

   // Called just after the accepting edge; follows the run to its done cycle.
   task automatic wait_done(input string tag, input logic [15:0] exp, input logic [15:0] prev);
      int n;
      int nb;
      bit seen;
      n = 0;
      nb = 0;
      seen = 0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (n == 5) check({tag, "_hold_prev"}, {16'd0, product}, {16'd0, prev});
         if (done) seen = 1;
      end
      check({tag, "_latency"}, n, 9);
      check({tag, "_busy_cycles"}, nb, 8);
      check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
   endtask

   task automatic run(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                      input logic [15:0] exp, input logic [15:0] prev);
      @(posedge clk);
      #1;
      a = ra;
      b = rb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~ra;
      b = ~rb;
      wait_done(tag, exp, prev);
   endtask

   initial begin
      total_checks = 0;
      passed_checks = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;

      #12;
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_product", {16'd0, product}, 32'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run("mul_0d_0b", 8'h0D, 8'h0B, 16'h008F, 16'h0000);
      run("mul_ff_ff", 8'hFF, 8'hFF, 16'hFE01, 16'h008F);
      run("mul_80_02", 8'h80, 8'h02, 16'h0100, 16'hFE01);
      run("mul_00_a5", 8'h00, 8'hA5, 16'h0000, 16'h0100);
      run("mul_a5_01", 8'hA5, 8'h01, 16'h00A5, 16'h0000);

      // start held high with operands churning every cycle after acceptance
      @(posedge clk);
      #1;
      a = 8'h0C;
      b = 8'h0C;
      start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         a = 8'($urandom);
         b = 8'($urandom);
      end
      check("hyg_done", {31'd0, done}, 32'd1);
      check("hyg_product", {16'd0, product}, 32'h0090);
      a = 8'h07;
      b = 8'h09;
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      wait_done("hyg_next", 16'h003F, 16'h0090);

      run("b2b_first", 8'h12, 8'h34, 16'h03A8, 16'h003F);
      run("b2b_second", 8'h56, 8'h78, 16'h2850, 16'h03A8);

      // asynchronous abort in the fourth computing cycle
      @(posedge clk);
      #1;
      a = 8'h9C;
      b = 8'h77;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_product", {16'd0, product}, 32'h0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", {31'd0, done}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_abort_idle", {31'd0, ready}, 32'd1);

      run("mul_03_05", 8'h03, 8'h05, 16'h000F, 16'h0000);

      @(posedge clk);
      @(posedge clk);
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
